// File: rtl/sdram_fifo_req_pkg.sv
// Shared constants and FSM encoding for the SDRAM ring-buffer FIFO requester.
package sdram_fifo_req_pkg;

   localparam int unsigned ADDR_W = 23;
   localparam int unsigned BLEN_W = 10;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StWrReq   = 3'd1,
      StWrBurst = 3'd2,
      StRdReq   = 3'd3,
      StRdBurst = 3'd4
   } state_e;

endpackage

// File: rtl/sdram_ring_ptr.sv
// Ring pointer: advances by one burst and wraps to ADDR_MIN past ADDR_MAX.
module sdram_ring_ptr
   import sdram_fifo_req_pkg::*;
#(
   parameter int unsigned       BURST_LEN = 8,
   parameter logic [ADDR_W-1:0] ADDR_MIN  = 23'd0,
   parameter logic [ADDR_W-1:0] ADDR_MAX  = 23'd63
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   output logic [ADDR_W-1:0] ptr
);

   localparam int unsigned PW = ADDR_W + 1;

   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [PW-1:0]     ptr_inc;

   // One extra bit so the increment cannot overflow before the wrap test.
   always_comb begin
      ptr_inc = {1'b0, ptr_q} + PW'(BURST_LEN);
      ptr_d   = ptr_q;
      if (advance) begin
         ptr_d = (ptr_inc > {1'b0, ADDR_MAX}) ? ADDR_MIN : ptr_inc[ADDR_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= ADDR_MIN;
      else     ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/sdram_fifo_req.sv
// Burst requester that uses an SDRAM region as a ring-buffer FIFO.
// Optional SDRAM_FIFO_RR_EN: round-robin tie-break between write and read.
module sdram_fifo_req
   import sdram_fifo_req_pkg::*;
#(
   parameter int unsigned       BURST_LEN  = 8,
   parameter logic [ADDR_W-1:0] ADDR_MIN   = 23'd0,
   parameter logic [ADDR_W-1:0] ADDR_MAX   = 23'd63,
   parameter int unsigned       FIFO_DEPTH = 1024
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [10:0]       wr_fifo_cnt,
   output logic              wr_fifo_rd_en,
   input  logic [15:0]       wr_fifo_dout,
   input  logic [10:0]       rd_fifo_cnt,
   output logic              rd_fifo_wr_en,
   output logic [15:0]       rd_fifo_din,
   input  logic              rd_run,
   output logic              sdram_wr_req,
   output logic [ADDR_W-1:0] sdram_wr_addr,
   output logic [15:0]       sdram_data_in,
   input  logic              sdram_wr_ack,
   output logic              sdram_rd_req,
   output logic [ADDR_W-1:0] sdram_rd_addr,
   input  logic [15:0]       sdram_data_out,
   input  logic              sdram_rd_ack,
   output logic [BLEN_W-1:0] wr_burst_len,
   output logic [BLEN_W-1:0] rd_burst_len,
   output logic              full,
   output logic              empty
);

   localparam int unsigned REGION = 32'(ADDR_MAX) - 32'(ADDR_MIN) + 32'd1;
   localparam int unsigned CAP    = REGION / BURST_LEN;
   localparam int unsigned FILL_W = $clog2(CAP + 1);

   localparam logic [FILL_W-1:0] CAP_F  = FILL_W'(CAP);
   localparam logic [10:0]       WR_MIN = 11'(BURST_LEN);
   localparam logic [10:0]       RD_MAX = 11'(FIFO_DEPTH - BURST_LEN);
   localparam logic [BLEN_W-1:0] LAST   = BLEN_W'(BURST_LEN - 1);

   state_e             state_q, state_d;
   logic [BLEN_W-1:0]  cnt_q, cnt_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               full_q, empty_q;
   logic               can_wr, can_rd, pick_wr;
   logic               wr_adv, rd_adv;

   assign can_wr = (wr_fifo_cnt >= WR_MIN) && (fill_q < CAP_F);
   assign can_rd = rd_run && (fill_q != '0) && (rd_fifo_cnt <= RD_MAX);

`ifdef SDRAM_FIFO_RR_EN
   logic last_grant_q, last_grant_d;

   // Only ties update the flag, so grants alternate among contested decisions.
   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == StIdle && can_wr && can_rd) last_grant_d = pick_wr;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) last_grant_q <= 1'b0;
      else         last_grant_q <= last_grant_d;
   end

   assign pick_wr = can_wr && (!can_rd || !last_grant_q);
`else
   assign pick_wr = can_wr;
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      fill_d        = fill_q;
      wr_adv        = 1'b0;
      rd_adv        = 1'b0;
      sdram_wr_req  = 1'b0;
      sdram_rd_req  = 1'b0;
      wr_fifo_rd_en = 1'b0;
      rd_fifo_wr_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (pick_wr)     state_d = StWrReq;
            else if (can_rd) state_d = StRdReq;
         end
         StWrReq, StWrBurst: begin
            sdram_wr_req  = (state_q == StWrReq);
            wr_fifo_rd_en = sdram_wr_ack && !sys_rst;
            if (sdram_wr_ack) begin
               if (cnt_q == LAST) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  wr_adv  = 1'b1;
                  fill_d  = fill_q + FILL_W'(1);
               end else begin
                  state_d = StWrBurst;
                  cnt_d   = cnt_q + BLEN_W'(1);
               end
            end
         end
         StRdReq, StRdBurst: begin
            sdram_rd_req  = (state_q == StRdReq);
            rd_fifo_wr_en = sdram_rd_ack && !sys_rst;
            if (sdram_rd_ack) begin
               if (cnt_q == LAST) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  rd_adv  = 1'b1;
                  fill_d  = fill_q - FILL_W'(1);
               end else begin
                  state_d = StRdBurst;
                  cnt_d   = cnt_q + BLEN_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         fill_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         full_q  <= (fill_q == CAP_F);
         empty_q <= (fill_q == '0);
      end
   end

   sdram_ring_ptr #(
      .BURST_LEN (BURST_LEN),
      .ADDR_MIN  (ADDR_MIN),
      .ADDR_MAX  (ADDR_MAX)
   ) u_wptr (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .advance (wr_adv),
      .ptr     (sdram_wr_addr)
   );

   sdram_ring_ptr #(
      .BURST_LEN (BURST_LEN),
      .ADDR_MIN  (ADDR_MIN),
      .ADDR_MAX  (ADDR_MAX)
   ) u_rptr (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .advance (rd_adv),
      .ptr     (sdram_rd_addr)
   );

   assign sdram_data_in = wr_fifo_dout;
   assign rd_fifo_din   = sdram_data_out;
   assign wr_burst_len  = BLEN_W'(BURST_LEN);
   assign rd_burst_len  = BLEN_W'(BURST_LEN);
   assign full          = full_q;
   assign empty         = empty_q;

endmodule

// File: tb/tb_sdram_fifo_req.sv
// Directed burst-level bench for sdram_fifo_req (BURST_LEN=8, ring 0..63, CAP=8).
module tb_sdram_fifo_req;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [10:0] wr_fifo_cnt;
   logic        wr_fifo_rd_en;
   logic [15:0] wr_fifo_dout;
   logic [10:0] rd_fifo_cnt;
   logic        rd_fifo_wr_en;
   logic [15:0] rd_fifo_din;
   logic        rd_run;
   logic        sdram_wr_req;
   logic [22:0] sdram_wr_addr;
   logic [15:0] sdram_data_in;
   logic        sdram_wr_ack;
   logic        sdram_rd_req;
   logic [22:0] sdram_rd_addr;
   logic [15:0] sdram_data_out;
   logic        sdram_rd_ack;
   logic [9:0]  wr_burst_len;
   logic [9:0]  rd_burst_len;
   logic        full;
   logic        empty;

   always #5 sys_clk = ~sys_clk;

   sdram_fifo_req dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .wr_fifo_cnt    (wr_fifo_cnt),
      .wr_fifo_rd_en  (wr_fifo_rd_en),
      .wr_fifo_dout   (wr_fifo_dout),
      .rd_fifo_cnt    (rd_fifo_cnt),
      .rd_fifo_wr_en  (rd_fifo_wr_en),
      .rd_fifo_din    (rd_fifo_din),
      .rd_run         (rd_run),
      .sdram_wr_req   (sdram_wr_req),
      .sdram_wr_addr  (sdram_wr_addr),
      .sdram_data_in  (sdram_data_in),
      .sdram_wr_ack   (sdram_wr_ack),
      .sdram_rd_req   (sdram_rd_req),
      .sdram_rd_addr  (sdram_rd_addr),
      .sdram_data_out (sdram_data_out),
      .sdram_rd_ack   (sdram_rd_ack),
      .wr_burst_len   (wr_burst_len),
      .rd_burst_len   (rd_burst_len),
      .full           (full),
      .empty          (empty)
   );

   // kind: 0 = no request expected, 1 = write burst, 2 = read burst
   typedef struct {
      logic [10:0] wcnt;
      logic [10:0] rcnt;
      logic        run;
      int          kind;
      logic [22:0] addr;
      logic        efull;
      logic        eempty;
   } vec_t;

   vec_t tbl[$];
   int   fm = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input int kind, input int addr, input int wc, input int rc, input bit run);
      vec_t v;
      if (kind == 1) fm++;
      else if (kind == 2) fm--;
      v.wcnt   = 11'(wc);
      v.rcnt   = 11'(rc);
      v.run    = run;
      v.kind   = kind;
      v.addr   = 23'(addr);
      v.efull  = (fm == 8);
      v.eempty = (fm == 0);
      tbl.push_back(v);
   endtask

   task automatic quiesce();
      wr_fifo_cnt  = 11'd0;
      rd_fifo_cnt  = 11'd0;
      rd_run       = 1'b0;
      sdram_wr_ack = 1'b0;
      sdram_rd_ack = 1'b0;
   endtask

   task automatic run_entry(input vec_t v, input int idx);
      int  waited;
      int  pops;
      int  pushes;
      bit  got;
      bit  held;
      bit  data_ok;
      int  act_kind;
      @(negedge sys_clk);
      wr_fifo_cnt = v.wcnt;
      rd_fifo_cnt = v.rcnt;
      rd_run      = v.run;
      if (v.kind == 0) begin
         got = 1'b0;
         repeat (20) begin
            @(negedge sys_clk);
            if (sdram_wr_req || sdram_rd_req) got = 1'b1;
         end
         check($sformatf("no_req[%0d]", idx), 32'(got), 32'd0);
      end else begin
         waited = 0;
         while (!(sdram_wr_req || sdram_rd_req) && waited < 20) begin
            @(negedge sys_clk);
            waited++;
         end
         act_kind = sdram_wr_req ? 1 : (sdram_rd_req ? 2 : 0);
         check($sformatf("req_kind[%0d]", idx), 32'(act_kind), 32'(v.kind));
         check($sformatf("req_addr[%0d]", idx),
               32'((v.kind == 1) ? sdram_wr_addr : sdram_rd_addr), 32'(v.addr));
         pops = 0; pushes = 0; held = 1'b0; data_ok = 1'b1;
         for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge sys_clk);
            if (v.kind == 1) sdram_wr_ack = 1'b1;
            else             sdram_rd_ack = 1'b1;
            sdram_data_out = 16'hA5A0 + 16'(i);
            #1;
            if (wr_fifo_rd_en) pops++;
            if (rd_fifo_wr_en) begin
               pushes++;
               if (rd_fifo_din !== 16'hA5A0 + 16'(i)) data_ok = 1'b0;
            end
            if (i == 1 && (sdram_wr_req || sdram_rd_req)) held = 1'b1;
         end
         @(negedge sys_clk);
         quiesce();
         check($sformatf("pops[%0d]", idx), 32'(pops), (v.kind == 1) ? 32'd8 : 32'd0);
         check($sformatf("pushes[%0d]", idx), 32'(pushes), (v.kind == 2) ? 32'd8 : 32'd0);
         check($sformatf("push_data[%0d]", idx), 32'(data_ok), 32'd1);
         check($sformatf("req_dropped[%0d]", idx), 32'(held), 32'd0);
      end
      quiesce();
      repeat (3) @(negedge sys_clk);
      check($sformatf("full[%0d]", idx), 32'(full), 32'(v.efull));
      check($sformatf("empty[%0d]", idx), 32'(empty), 32'(v.eempty));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   pops;
      int   pushes;
      int   waited;
      vec_t v;

      sys_rst        = 1'b1;
      wr_fifo_dout   = 16'h1234;
      sdram_data_out = 16'h0;
      quiesce();
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);

      check("rst_wr_req", 32'(sdram_wr_req), 32'd0);
      check("rst_rd_req", 32'(sdram_rd_req), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_wptr", 32'(sdram_wr_addr), 32'd0);
      check("rst_rptr", 32'(sdram_rd_addr), 32'd0);
      check("burst_len", {12'd0, wr_burst_len, rd_burst_len}, {12'd0, 10'd8, 10'd8});
      check("data_passthru", 32'(sdram_data_in), 32'h1234);

      // Stray acks in IDLE must not pop or push.
      pops = 0; pushes = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         sdram_wr_ack = 1'b1;
         sdram_rd_ack = 1'b1;
         #1;
         if (wr_fifo_rd_en) pops++;
         if (rd_fifo_wr_en) pushes++;
      end
      @(negedge sys_clk);
      quiesce();
      check("stray_pops", 32'(pops), 32'd0);
      check("stray_pushes", 32'(pushes), 32'd0);

      for (int i = 0; i < 8; i++) add(1, i * 8, 8, 0, 0);
      add(0, 0, 8, 0, 0);
      add(0, 0, 0, 1017, 1);
      add(2, 0, 0, 1016, 1);
      add(1, 0, 8, 0, 0);
      for (int i = 0; i < 8; i++) add(2, ((i + 1) * 8) % 64, 0, 0, 1);
      add(1, 8, 8, 0, 0);
      add(1, 16, 8, 0, 0);
`ifdef SDRAM_FIFO_RR_EN
      add(1, 24, 8, 0, 1);
      add(2, 8, 8, 0, 1);
      add(1, 32, 8, 0, 1);
      add(2, 16, 8, 0, 1);
`else
      add(1, 24, 8, 0, 1);
      add(1, 32, 8, 0, 1);
      add(2, 8, 7, 0, 1);
      add(2, 16, 7, 0, 1);
`endif

      foreach (tbl[i]) run_entry(tbl[i], i);

      // Reset in the middle of a write burst (wptr = 40, rptr = 24, fill = 2).
      @(negedge sys_clk);
      wr_fifo_cnt = 11'd8;
      waited = 0;
      while (!sdram_wr_req && waited < 20) begin
         @(negedge sys_clk);
         waited++;
      end
      check("mid_req_addr", 32'(sdram_wr_addr), 32'd40);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge sys_clk);
         sdram_wr_ack = 1'b1;
      end
      wr_fifo_cnt = 11'd0;
      @(negedge sys_clk);
      sys_rst = 1'b1;
      pops = 0;
      #1;
      if (wr_fifo_rd_en) pops++;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      check("mid_rst_wr_req", 32'(sdram_wr_req), 32'd0);
      check("mid_rst_rd_req", 32'(sdram_rd_req), 32'd0);
      check("mid_rst_wptr", 32'(sdram_wr_addr), 32'd0);
      check("mid_rst_rptr", 32'(sdram_rd_addr), 32'd0);
      check("mid_rst_empty", 32'(empty), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge sys_clk);
         #1;
         if (wr_fifo_rd_en) pops++;
      end
      @(negedge sys_clk);
      quiesce();
      check("mid_rst_pops", 32'(pops), 32'd0);

      // After reset the ring starts over at ADDR_MIN with fill = 0.
      v.wcnt = 11'd8; v.rcnt = 11'd0; v.run = 1'b0; v.kind = 1;
      v.addr = 23'd0; v.efull = 1'b0; v.eempty = 1'b0;
      run_entry(v, 99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
